// File: rtl/sdii_pkg.sv
// rtl/sdii_pkg.sv - shared defaults and helpers for the counter snapshot path
package sdii_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int DEPTH_DEF      = 4;

  // level counts 0..depth inclusive, so it needs one bit more than a pointer
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/count_wrap_detect.sv
// rtl/count_wrap_detect.sv - registered all-ones-to-zero wrap detector
module count_wrap_detect
  import sdii_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] cr_data_input,
  output logic                  wrap_pulse
);

  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  wrap_q, wrap_d;

  always_comb begin
    prev_d = cr_data_input;
    wrap_d = (prev_q == {DATA_WIDTH{1'b1}}) && (cr_data_input == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap_pulse = wrap_q;

endmodule

// File: rtl/count_snapshot_fifo.sv
// rtl/count_snapshot_fifo.sv - snapshot FIFO for counter values with overflow and wrap reporting
module count_snapshot_fifo
  import sdii_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         cr_data_input,
  input  logic                          cap_valid,
  output logic                          cap_ready,
  input  logic                          clear,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          wrap_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop;

  // all handshake outputs come from registered state only
  assign cap_ready = (level_q != LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;

  assign push = cap_valid && cap_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = cr_data_input;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (cap_valid && !cap_ready) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  count_wrap_detect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wrap (
    .clk           (clk),
    .reset         (reset),
    .cr_data_input (cr_data_input),
    .wrap_pulse    (wrap_pulse)
  );

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// tb/tb_count_snapshot_fifo.sv - directed self-checking bench for count_snapshot_fifo
module tb_count_snapshot_fifo;

  logic       clk;
  logic       reset;
  logic [3:0] cr_data_input;
  logic       cap_valid;
  logic       cap_ready;
  logic       clear;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       overflow;
  logic       wrap_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  count_snapshot_fifo dut (
    .clk           (clk),
    .reset         (reset),
    .cr_data_input (cr_data_input),
    .cap_valid     (cap_valid),
    .cap_ready     (cap_ready),
    .clear         (clear),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .level         (level),
    .overflow      (overflow),
    .wrap_pulse    (wrap_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"},     32'(level),      32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid),  32'd0);
    chk({tag, "_cap_ready"}, 32'(cap_ready),  32'd1);
    chk({tag, "_out_data"},  32'(out_data),   32'd0);
    chk({tag, "_overflow"},  32'(overflow),   32'd0);
    chk({tag, "_wrap"},      32'(wrap_pulse), 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    cr_data_input = 4'd0;
    cap_valid     = 1'b0;
    clear         = 1'b0;
    out_ready     = 1'b0;
    #1;
    chk_reset_state("rst");
    @(negedge clk);
    reset = 1'b1;

    // capture 3,4,5 then drain
    cap_valid = 1'b1;
    cr_data_input = 4'd3; tick();
    chk("lat_out_data", 32'(out_data), 32'd3);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    cr_data_input = 4'd4; tick();
    cr_data_input = 4'd5; tick();
    cap_valid = 1'b0;
    chk("t1_level", 32'(level), 32'd3);
    chk("t1_head", 32'(out_data), 32'd3);
    out_ready = 1'b1;
    tick(); chk("t1_pop4", 32'(out_data), 32'd4);
    tick(); chk("t1_pop5", 32'(out_data), 32'd5);
    tick();
    chk("t1_empty_valid", 32'(out_valid), 32'd0);
    chk("t1_empty_data", 32'(out_data), 32'd0);
    chk("t1_empty_level", 32'(level), 32'd0);
    out_ready = 1'b0;

    // fill 1..4, rejected 9, drain
    cap_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cr_data_input = 4'(i);
      tick();
    end
    chk("t2_full_level", 32'(level), 32'd4);
    chk("t2_full_ready", 32'(cap_ready), 32'd0);
    chk("t2_ovf_before", 32'(overflow), 32'd0);
    cr_data_input = 4'd9; tick();
    cap_valid = 1'b0;
    chk("t2_ovf_set", 32'(overflow), 32'd1);
    chk("t2_level_hold", 32'(level), 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t2_drain%0d", i), 32'(out_data), 32'(i));
      tick();
    end
    chk("t2_drained", 32'(out_valid), 32'd0);
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);
    out_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t2_clear_ovf", 32'(overflow), 32'd0);

    // FULL with simultaneous capture and pop
    cap_valid = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      cr_data_input = 4'(i);
      tick();
    end
    cr_data_input = 4'd9;
    out_ready = 1'b1;
    tick();
    cap_valid = 1'b0;
    out_ready = 1'b0;
    chk("t3_level", 32'(level), 32'd3);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_head", 32'(out_data), 32'd6);
    cap_valid = 1'b1;
    cr_data_input = 4'd10; tick();
    chk("t3_refull", 32'(level), 32'd4);
    cr_data_input = 4'd11;
    clear = 1'b1; tick();
    clear = 1'b0;
    cap_valid = 1'b0;
    chk("t3_clr_level", 32'(level), 32'd0);
    chk("t3_clr_ovf", 32'(overflow), 32'd0);
    chk("t3_clr_valid", 32'(out_valid), 32'd0);
    chk("t3_clr_ready", 32'(cap_ready), 32'd1);

    // PARTIAL push+pop keeps level
    cap_valid = 1'b1;
    cr_data_input = 4'd12; tick();
    cr_data_input = 4'd13; tick();
    chk("t4_level2", 32'(level), 32'd2);
    cr_data_input = 4'd7;
    out_ready = 1'b1;
    tick();
    cap_valid = 1'b0;
    chk("t4_level_same", 32'(level), 32'd2);
    chk("t4_head13", 32'(out_data), 32'd13);
    tick(); chk("t4_last7", 32'(out_data), 32'd7);
    tick(); chk("t4_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // wrap detection
    cr_data_input = 4'd14; tick(); chk("wrap_14", 32'(wrap_pulse), 32'd0);
    cr_data_input = 4'd15; tick(); chk("wrap_15", 32'(wrap_pulse), 32'd0);
    cr_data_input = 4'd0;  tick(); chk("wrap_0", 32'(wrap_pulse), 32'd1);
    cr_data_input = 4'd1;  tick(); chk("wrap_1", 32'(wrap_pulse), 32'd0);

    // mid-stream asynchronous reset with prev holding all-ones
    cap_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cr_data_input = 4'd15;
      tick();
    end
    chk("t6_pre_ovf", 32'(overflow), 32'd1);
    chk("t6_pre_level", 32'(level), 32'd4);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_state("midrst");
    cap_valid = 1'b0;
    cr_data_input = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("t6_no_wrap", 32'(wrap_pulse), 32'd0);
    cap_valid = 1'b1;
    cr_data_input = 4'd6; tick();
    cap_valid = 1'b0;
    chk("t6_push_level", 32'(level), 32'd1);
    chk("t6_push_data", 32'(out_data), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
